// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: redirect, instruction-memory request/response and decode handshake.
// master = fetch unit side, slave = PC/branch logic, memory and decode side.
interface fetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instruction, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order prefetch queue between PC/branch logic and decode, with redirect flush.
// Optional stall counter port enabled by defining FETCH_QUEUE_PERF_EN.
module fetch_queue #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_queue_if.master      fq
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DISC_W = PTR_W + 2;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  slot_pc_q   [DEPTH];
  logic [XLEN-1:0]  slot_pc_d   [DEPTH];
  logic [XLEN-1:0]  slot_data_q [DEPTH];
  logic [XLEN-1:0]  slot_data_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PTR_W-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, pend_q, pend_d;
  logic [DISC_W-1:0] disc_q, disc_d;

  logic req, valid, alloc, drop, fill, pop;
  logic unused_pc_bits;

  assign unused_pc_bits = ^fq.redirect_pc[1:0];

  // Request, drain and next-state logic; redirect overrides allocate/fill/pop.
  always_comb begin
    req   = !reset && (count_q < CNT_W'(DEPTH)) && !fq.redirect_valid;
    valid = filled_q[head_q] && (count_q != '0);
    alloc = req && fq.imem_gnt;
    drop  = fq.imem_rvalid && (disc_q != '0);
    fill  = fq.imem_rvalid && (disc_q == '0) && (pend_q != '0);
    pop   = valid && fq.instr_ready;

    fq.imem_req    = req;
    fq.imem_addr   = fetch_pc_q;
    fq.instr_valid = valid;
    fq.instruction = slot_data_q[head_q];
    fq.instr_pc    = slot_pc_q[head_q];

    fetch_pc_d  = fetch_pc_q;
    slot_pc_d   = slot_pc_q;
    slot_data_d = slot_data_q;
    filled_d    = filled_q;
    head_d      = head_q;
    fill_d      = fill_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pend_d      = pend_q;
    disc_d      = disc_q;

    if (fq.redirect_valid) begin
      fetch_pc_d = {fq.redirect_pc[XLEN-1:2], 2'b00};
      head_d     = '0;
      fill_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      pend_d     = '0;
      filled_d   = '0;
      // Everything still owed by memory becomes garbage, minus a response landing now.
      disc_d     = disc_q + DISC_W'(pend_q) - DISC_W'(drop || fill);
    end else begin
      if (alloc) begin
        slot_pc_d[tail_q] = fetch_pc_q;
        filled_d[tail_q]  = 1'b0;
        tail_d            = tail_q + PTR_W'(1);
        fetch_pc_d        = fetch_pc_q + XLEN'(4);
      end
      if (drop) begin
        disc_d = disc_q - DISC_W'(1);
      end
      if (fill) begin
        slot_data_d[fill_q] = fq.imem_rdata;
        filled_d[fill_q]    = 1'b1;
        fill_d              = fill_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
      pend_d  = pend_q + CNT_W'(alloc) - CNT_W'(fill);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_pc_q[i]   <= '0;
        slot_data_q[i] <= '0;
      end
      filled_q <= '0;
      head_q   <= '0;
      fill_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      disc_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      slot_pc_q   <= slot_pc_d;
      slot_data_q <= slot_data_d;
      filled_q    <= filled_d;
      head_q      <= head_d;
      fill_q      <= fill_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      disc_q      <= disc_d;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Decode wanted an instruction but none was ready.
  always_comb begin
    stall_d = stall_q;
    if (fq.instr_ready && !valid && !fq.redirect_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

  // A response with nothing outstanding is a memory protocol violation.
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (reset)
    !(fq.imem_rvalid && (disc_q == '0) && (pend_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-level reference model plus directed scenarios.
module tb_fetch_queue;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN)) fq ();
  fetch_queue_if #(.XLEN(XLEN)) fw ();

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cycles, stall_cycles2;
`endif

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .fq(fq)
`ifdef FETCH_QUEUE_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .fq(fw)
`ifdef FETCH_QUEUE_PERF_EN
    , .stall_cycles(stall_cycles2)
`endif
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory: in-order responses, at least one cycle after grant, when rsp_en allows.
  bit          rsp_en = 1'b0;
  logic [31:0] mem_q[$];
  int          grants = 0;

  always @(posedge clk) begin
    #2;
    if (!reset && rsp_en && mem_q.size() > 0) begin
      fq.imem_rvalid = 1'b1;
      fq.imem_rdata  = mdata(mem_q[0]);
    end else begin
      fq.imem_rvalid = 1'b0;
      fq.imem_rdata  = '0;
    end
  end

  // Reference model: allocated slots in program order, plus count of responses to throw away.
  logic [31:0] q_pc[$];
  logic [31:0] q_data[$];
  bit          q_fill[$];
  logic [31:0] m_pc = 32'h0;
  int          m_disc = 0;
  logic [31:0] m_stall = 32'h0;

  always @(negedge clk) begin
    bit exp_req, exp_valid, done;
    int pend;
    if (reset) begin
      q_pc.delete(); q_data.delete(); q_fill.delete();
      m_pc = 32'h0; m_disc = 0; m_stall = 32'h0;
      mem_q.delete();
    end else begin
      exp_req   = (q_pc.size() < DEPTH) && !fq.redirect_valid;
      exp_valid = (q_pc.size() > 0) && q_fill[0];
      chk("imem_req", 32'(fq.imem_req), 32'(exp_req));
      chk("imem_addr", fq.imem_addr, m_pc);
      chk("instr_valid", 32'(fq.instr_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("instr_pc", fq.instr_pc, q_pc[0]);
        chk("instruction", fq.instruction, q_data[0]);
      end
`ifdef FETCH_QUEUE_PERF_EN
      chk("stall_cycles", stall_cycles, m_stall);
      if (fq.instr_ready && !exp_valid && !fq.redirect_valid && m_stall != 32'hFFFF_FFFF)
        m_stall = m_stall + 32'd1;
`endif
      if (fq.imem_req && fq.imem_gnt) begin
        mem_q.push_back(fq.imem_addr);
        grants++;
      end
      if (fq.imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());

      if (fq.redirect_valid) begin
        pend = 0;
        foreach (q_fill[i]) if (!q_fill[i]) pend++;
        pend = pend + m_disc;
        if (fq.imem_rvalid && pend > 0) pend--;
        m_disc = pend;
        q_pc.delete(); q_data.delete(); q_fill.delete();
        m_pc = {fq.redirect_pc[31:2], 2'b00};
      end else begin
        if (fq.imem_rvalid) begin
          if (m_disc > 0) m_disc--;
          else begin
            done = 1'b0;
            foreach (q_fill[i]) if (!done && !q_fill[i]) begin
              q_fill[i] = 1'b1;
              q_data[i] = fq.imem_rdata;
              done = 1'b1;
            end
          end
        end
        if (exp_valid && fq.instr_ready) begin
          void'(q_pc.pop_front()); void'(q_data.pop_front()); void'(q_fill.pop_front());
        end
        if (exp_req && fq.imem_gnt) begin
          q_pc.push_back(m_pc); q_data.push_back(32'h0); q_fill.push_back(1'b0);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    #6;
  endtask

  task automatic drain();
    fq.imem_gnt = 1'b0; rsp_en = 1'b1; fq.instr_ready = 1'b1;
    repeat (8) step();
  endtask

  task automatic wait_first(input string nm, input logic [31:0] pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(); samp();
      if (fq.instr_valid) begin
        chk({nm, "_pc"}, fq.instr_pc, pc);
        chk({nm, "_data"}, fq.instruction, mdata(pc));
        seen = 1'b1;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_req"}, 32'(fq.imem_req), 32'd0);
    chk({nm, "_addr"}, fq.imem_addr, 32'h0);
    chk({nm, "_valid"}, 32'(fq.instr_valid), 32'd0);
    chk({nm, "_instr"}, fq.instruction, 32'h0);
    chk({nm, "_pc"}, fq.instr_pc, 32'h0);
`ifdef FETCH_QUEUE_PERF_EN
    chk({nm, "_stall"}, stall_cycles, 32'h0);
`endif
  endtask

  initial begin
    int first_valid;
    fq.redirect_valid = 1'b0; fq.redirect_pc = '0;
    fq.imem_gnt = 1'b0; fq.instr_ready = 1'b0;
    fw.redirect_valid = 1'b0; fw.redirect_pc = '0;
    fw.imem_gnt = 1'b1; fw.imem_rvalid = 1'b0; fw.imem_rdata = '0; fw.instr_ready = 1'b0;

    repeat (3) step();
    #3;
    chk_reset_outputs("reset");
    chk("wrap_reset_addr", fw.imem_addr, 32'hFFFF_FFFC);

    // Backpressure from reset release: only DEPTH grants while decode stalls.
    step();
    reset = 1'b0; fq.imem_gnt = 1'b1; rsp_en = 1'b1; fq.instr_ready = 1'b0;
    grants = 0; first_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      samp();
      if (k == 1) chk("wrap_addr0", fw.imem_addr, 32'hFFFF_FFFC);
      if (k == 2) chk("wrap_addr1", fw.imem_addr, 32'h0000_0000);
      if (first_valid == 0 && fq.instr_valid) first_valid = k;
      if (k == 10) chk("full_req", 32'(fq.imem_req), 32'd0);
      step();
    end
    chk("first_valid_cycle", 32'(first_valid), 32'd3);
    chk("bp_grants", 32'(grants), 32'd4);

    // Release decode: one instruction per cycle, in order, from PC 0.
    fq.instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      samp();
      chk("stream_valid", 32'(fq.instr_valid), 32'd1);
      chk("stream_pc", fq.instr_pc, 32'(4 * k));
      step();
    end

    // Redirect with three responses still owed by memory.
    drain();
    rsp_en = 1'b0; fq.imem_gnt = 1'b1;
    repeat (3) step();
    fq.imem_gnt = 1'b0; fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h0000_1003;
    samp();
    chk("redir_req_low", 32'(fq.imem_req), 32'd0);
    step();
    fq.redirect_valid = 1'b0; rsp_en = 1'b1; fq.imem_gnt = 1'b1;
    samp();
    chk("redir_valid_low", 32'(fq.instr_valid), 32'd0);
    chk("redir_addr", fq.imem_addr, 32'h0000_1000);
    wait_first("redir3", 32'h0000_1000);
    step();

    // Redirect coincident with a response and a would-be pop.
    drain();
    fq.instr_ready = 1'b0; fq.imem_gnt = 1'b1; rsp_en = 1'b1;
    step();
    step();
    rsp_en = 1'b0;
    step();
    step();
    fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h0000_2000; fq.instr_ready = 1'b1; rsp_en = 1'b1;
    samp();
    chk("coinc_req_low", 32'(fq.imem_req), 32'd0);
    chk("coinc_valid", 32'(fq.instr_valid), 32'd1);
    chk("coinc_rvalid", 32'(fq.imem_rvalid), 32'd1);
    step();
    fq.redirect_valid = 1'b0;
    samp();
    chk("coinc_valid_low", 32'(fq.instr_valid), 32'd0);
    chk("coinc_addr", fq.imem_addr, 32'h0000_2000);
    wait_first("coinc", 32'h0000_2000);
    step();

    // Reset while full with two stale responses outstanding.
    drain();
    rsp_en = 1'b0; fq.instr_ready = 1'b0; fq.imem_gnt = 1'b1;
    step();
    step();
    fq.imem_gnt = 1'b0; fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h0000_3000;
    step();
    fq.redirect_valid = 1'b0; fq.imem_gnt = 1'b1;
    repeat (6) step();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    step();
    step();
    reset = 1'b0; rsp_en = 1'b1; fq.instr_ready = 1'b1; fq.imem_gnt = 1'b1;
    samp();
    chk("restart_addr", fq.imem_addr, 32'h0000_0000);
    wait_first("restart", 32'h0000_0000);
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
